dwconv_dispatch_ctrl: RTL and testbench

- Command-side initiator for the depthwise-conv compute unit.
- Accepts layer descriptors from the softcore into a small queue and drives the unit's start / pointer / dimension interface one job at a time.
- Waits for the unit's done pulse, captures the result word, and returns a tagged response with status to the softcore.

---
 rtl/dwconv_dispatch_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_dwconv_dispatch_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwconv_dispatch_ctrl.sv
// dwconv_dispatch_ctrl: queues layer descriptors and runs them one at a time
// on the depthwise-conv unit, returning a tagged result/status per job.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_*               descriptor push (valid/ready), tag, 3 ptrs,
//                       3 dims, stride, padding
//   unit_start, unit_*  start pulse and operands to the compute unit
//   unit_result/done/ready  result word, done pulse, idle flag
//   rsp_*               response (valid/ready), tag, result, status
//   busy, queue_count   activity flag and queue occupancy
//
// Optional: define DWCONV_DISPATCH_TIMEOUT_EN to abort a job that has not
// signalled done within TIMEOUT cycles of WAIT_DONE (status 1).
module dwconv_dispatch_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_tag,
  input  logic [31:0]              cmd_input_ptr,
  input  logic [31:0]              cmd_filter_ptr,
  input  logic [31:0]              cmd_output_ptr,
  input  logic [31:0]              cmd_input_dims,
  input  logic [31:0]              cmd_filter_dims,
  input  logic [31:0]              cmd_output_dims,
  input  logic [31:0]              cmd_stride,
  input  logic [31:0]              cmd_padding,
  output logic                     unit_start,
  output logic [31:0]              unit_input_ptr,
  output logic [31:0]              unit_filter_ptr,
  output logic [31:0]              unit_output_ptr,
  output logic [31:0]              unit_input_dims,
  output logic [31:0]              unit_filter_dims,
  output logic [31:0]              unit_output_dims,
  output logic [31:0]              unit_stride,
  output logic [31:0]              unit_padding,
  input  logic [31:0]              unit_result,
  input  logic                     unit_done,
  input  logic                     unit_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_tag,
  output logic [31:0]              rsp_result,
  output logic [1:0]               rsp_status,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_TO  = 2'd1;
  localparam logic [1:0] ST_BAD = 2'd2;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] ip;
    logic [31:0] fp;
    logic [31:0] op;
    logic [31:0] idims;
    logic [31:0] fdims;
    logic [31:0] odims;
    logic [31:0] stride;
    logic [31:0] pad;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t         state;
  state_t         state_nx;
  desc_t          mem [DEPTH];
  desc_t          cmd_d;
  desc_t          head;
  desc_t          op_q;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [31:0]    res_q;
  logic [1:0]     sts_q;
  logic           push;
  logic           pop;
  logic           bad;
  logic           done_ok;
  logic           timed_out;

  assign cmd_d = {cmd_tag, cmd_input_ptr, cmd_filter_ptr,
                  cmd_output_ptr, cmd_input_dims, cmd_filter_dims,
                  cmd_output_dims, cmd_stride, cmd_padding};

  assign head      = mem[rd_ptr];
  assign cmd_ready = count < (AW+1)'(DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0) && unit_ready;

  // Zero channels or a zero stride cannot be computed; reject at pop.
  assign bad = (head.idims[7:0] == 8'd0)
            || (head.stride[31:16] == 16'd0)
            || (head.stride[15:0] == 16'd0);

  assign done_ok = (state == WAIT_DONE) && unit_done;

`ifdef DWCONV_DISPATCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] to_cnt;

  // Cleared in ISSUE so the first WAIT_DONE cycle sees 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // A done in the final cycle takes precedence over the abort.
  assign timed_out = (state == WAIT_DONE) && !unit_done
                  && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pop) begin
          state_nx = bad ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_ok || timed_out) begin
          state_nx = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_d;
    end
  end

  // Operands are only reloaded on pop, which cannot happen until the
  // response has been taken, so they stay put for the whole job.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      res_q <= '0;
      sts_q <= ST_OK;
    end else begin
      if (pop) begin
        op_q <= head;
        if (bad) begin
          res_q <= '0;
          sts_q <= ST_BAD;
        end
      end
      if (done_ok) begin
        res_q <= unit_result;
        sts_q <= ST_OK;
      end else if (timed_out) begin
        res_q <= '0;
        sts_q <= ST_TO;
      end
    end
  end

  assign unit_start       = (state == ISSUE);
  assign unit_input_ptr   = op_q.ip;
  assign unit_filter_ptr  = op_q.fp;
  assign unit_output_ptr  = op_q.op;
  assign unit_input_dims  = op_q.idims;
  assign unit_filter_dims = op_q.fdims;
  assign unit_output_dims = op_q.odims;
  assign unit_stride      = op_q.stride;
  assign unit_padding     = op_q.pad;

  assign rsp_valid  = (state == RESPOND);
  assign rsp_tag    = op_q.tag;
  assign rsp_result = res_q;
  assign rsp_status = sts_q;

  assign busy        = (state != IDLE) || (count != '0);
  assign queue_count = count;

endmodule

// File: tb/tb_dwconv_dispatch_ctrl.sv
// tb_dwconv_dispatch_ctrl: table, directed and random checks of the
// dispatcher against a queue-based reference and a behavioural unit.
module tb_dwconv_dispatch_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam logic [31:0] K = 32'hA5A5_3C3C;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_tag;
  logic [31:0] cmd_input_ptr, cmd_filter_ptr, cmd_output_ptr;
  logic [31:0] cmd_input_dims, cmd_filter_dims, cmd_output_dims;
  logic [31:0] cmd_stride, cmd_padding;
  logic        unit_start;
  logic [31:0] unit_input_ptr, unit_filter_ptr, unit_output_ptr;
  logic [31:0] unit_input_dims, unit_filter_dims, unit_output_dims;
  logic [31:0] unit_stride, unit_padding;
  logic [31:0] unit_result = 32'd0;
  logic        unit_done = 1'b0;
  logic        unit_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_tag;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [2:0]  queue_count;

  always #5 clk = ~clk;

  dwconv_dispatch_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
    .cmd_input_ptr(cmd_input_ptr), .cmd_filter_ptr(cmd_filter_ptr),
    .cmd_output_ptr(cmd_output_ptr), .cmd_input_dims(cmd_input_dims),
    .cmd_filter_dims(cmd_filter_dims), .cmd_output_dims(cmd_output_dims),
    .cmd_stride(cmd_stride), .cmd_padding(cmd_padding),
    .unit_start(unit_start),
    .unit_input_ptr(unit_input_ptr), .unit_filter_ptr(unit_filter_ptr),
    .unit_output_ptr(unit_output_ptr), .unit_input_dims(unit_input_dims),
    .unit_filter_dims(unit_filter_dims),
    .unit_output_dims(unit_output_dims),
    .unit_stride(unit_stride), .unit_padding(unit_padding),
    .unit_result(unit_result), .unit_done(unit_done),
    .unit_ready(unit_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .busy(busy), .queue_count(queue_count)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] ip, fp, opt, idims, fdims, odims, stride, pad;
  } desc_t;

  typedef struct {
    desc_t       d;
    logic [31:0] res;
    logic [1:0]  sts;
  } exp_t;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] idims;
    logic [31:0] stride;
    logic [1:0]  sts;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int starts = 0;
  int exp_starts = 0;
  int rsp_cnt = 0;
  logic [7:0]  last_tag = 8'd0;
  logic [31:0] last_res = 32'd0;
  logic [1:0]  last_sts = 2'd0;
  bit hang = 1'b0;
  int lat_fix = 0;
  int ucnt = 0;
  logic [31:0] ures = 32'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural unit: done 'lat' cycles after start, result = ip ^ K.
  always @(negedge clk) begin
    unit_done   = 1'b0;
    unit_result = $urandom;
    if (rst) begin
      starts = 0;
    end
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        unit_done   = 1'b1;
        unit_result = ures;
      end
    end
    if (!rst && unit_start) begin
      starts++;
      chk("start_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("op_ip", unit_input_ptr, sb[0].d.ip);
        chk("op_fp", unit_filter_ptr, sb[0].d.fp);
        chk("op_op", unit_output_ptr, sb[0].d.opt);
        chk("op_idims", unit_input_dims, sb[0].d.idims);
        chk("op_fdims", unit_filter_dims, sb[0].d.fdims);
        chk("op_odims", unit_output_dims, sb[0].d.odims);
        chk("op_stride", unit_stride, sb[0].d.stride);
        chk("op_pad", unit_padding, sb[0].d.pad);
      end
      if (!hang) begin
        ucnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 6);
        ures = unit_input_ptr ^ K;
      end
    end
  end

  // Every cycle a response is shown it must match the oldest job.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      chk("start_in_rsp", 32'(unit_start), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got tag %h expected none", rsp_tag);
      end else begin
        chk("rsp_tag", rsp_tag, sb[0].d.tag);
        chk("rsp_result", rsp_result, sb[0].res);
        chk("rsp_status", rsp_status, sb[0].sts);
        if (rsp_ready) begin
          last_tag = rsp_tag;
          last_res = rsp_result;
          last_sts = rsp_status;
          void'(sb.pop_front());
          rsp_cnt++;
        end
      end
    end
  end

  function automatic desc_t mk(input logic [7:0] tag,
                               input logic [31:0] idims,
                               input logic [31:0] stride);
    desc_t d;
    d.tag    = tag;
    d.ip     = $urandom;
    d.fp     = $urandom;
    d.opt    = $urandom;
    d.idims  = idims;
    d.fdims  = $urandom;
    d.odims  = $urandom;
    d.stride = stride;
    d.pad    = $urandom;
    return d;
  endfunction

  task automatic push(input desc_t d, input bit to_exp);
    int   n = 0;
    bit   bad;
    exp_t e;
    cmd_tag         = d.tag;
    cmd_input_ptr   = d.ip;
    cmd_filter_ptr  = d.fp;
    cmd_output_ptr  = d.opt;
    cmd_input_dims  = d.idims;
    cmd_filter_dims = d.fdims;
    cmd_output_dims = d.odims;
    cmd_stride      = d.stride;
    cmd_padding     = d.pad;
    cmd_valid       = 1'b1;
    while (!cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: got cmd_ready 0 expected 1 tag %h", d.tag);
      cmd_valid = 1'b0;
      return;
    end
    bad = (d.idims[7:0] == 0) || (d.stride[31:16] == 0)
       || (d.stride[15:0] == 0);
    e.d   = d;
    e.sts = bad ? 2'd2 : (to_exp ? 2'd1 : 2'd0);
    e.res = (bad || to_exp) ? 32'd0 : (d.ip ^ K);
    sb.push_back(e);
    if (!bad) exp_starts++;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 3000) begin
      tick();
      n++;
    end
    chk("rsp_wait", 32'(rsp_cnt >= target), 32'd1);
  endtask

  vec_t  vt[6];
  desc_t d0;
  desc_t d1;
  int    base;
  int    s0;
  bit    found;

  initial begin
    vt[0] = '{8'h21, 32'h0108_0803, 32'h0001_0001, 2'd0};
    vt[1] = '{8'h22, 32'h0108_0800, 32'h0001_0001, 2'd2};
    vt[2] = '{8'h23, 32'h0108_08FF, 32'h0000_0002, 2'd2};
    vt[3] = '{8'h24, 32'h0108_0810, 32'h0002_0000, 2'd2};
    vt[4] = '{8'h25, 32'h0000_0001, 32'hFFFF_FFFF, 2'd0};
    vt[5] = '{8'h26, 32'hFFFF_FF80, 32'h0002_0003, 2'd0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_tag = '0;
    cmd_input_ptr = '0;
    cmd_filter_ptr = '0;
    cmd_output_ptr = '0;
    cmd_input_dims = '0;
    cmd_filter_dims = '0;
    cmd_output_dims = '0;
    cmd_stride = '0;
    cmd_padding = '0;
    rsp_ready = 1'b1;
    unit_ready = 1'b1;
    tick(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_start", 32'(unit_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_unit_ip", unit_input_ptr, 32'd0);
    rst = 1'b0;
    tick();

    // Single job: push-to-start latency and expected result 0x9.
    lat_fix = 5;
    d0 = mk(8'h11, 32'h0108_0803, 32'h0001_0001);
    d0.ip = 32'h0000_0009 ^ K;
    push(d0, 1'b0);
    chk("lat_t1", 32'(unit_start), 32'd0);
    tick();
    chk("lat_t2", 32'(unit_start), 32'd1);
    tick();
    chk("lat_t3", 32'(unit_start), 32'd0);
    wait_rsp(1);
    chk("single_tag", last_tag, 8'h11);
    chk("single_res", last_res, 32'h0000_0009);
    chk("single_sts", last_sts, 2'd0);

    // Table vectors.
    lat_fix = 0;
    for (int i = 0; i < 6; i++) begin
      d0 = mk(vt[i].tag, vt[i].idims, vt[i].stride);
      push(d0, 1'b0);
      wait_rsp(rsp_cnt + 1);
      chk("vec_tag", last_tag, vt[i].tag);
      chk("vec_sts", last_sts, vt[i].sts);
      chk("vec_res", last_res, (vt[i].sts == 2'd0) ? (d0.ip ^ K) : 32'd0);
    end
    chk("vec_starts", starts, exp_starts);

    // Queue fill with the unit held busy.
    unit_ready = 1'b0;
    base = rsp_cnt;
    for (int i = 1; i <= 4; i++) begin
      push(mk(8'(i), 32'h0101_0101, 32'h0001_0001), 1'b0);
    end
    tick(2);
    chk("fill_count", 32'(queue_count), 32'd4);
    chk("fill_ready", 32'(cmd_ready), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    unit_ready = 1'b1;
    wait_rsp(base + 4);
    chk("fill_last_tag", last_tag, 8'd4);
    push(mk(8'd5, 32'h0101_0101, 32'h0001_0001), 1'b0);
    wait_rsp(base + 5);
    chk("fill_tag5", last_tag, 8'd5);

    // Bad dims followed by a good job: only one start.
    s0 = starts;
    base = rsp_cnt;
    push(mk(8'h30, 32'h0105_0500, 32'h0001_0001), 1'b0);
    push(mk(8'h31, 32'h0105_0504, 32'h0001_0001), 1'b0);
    wait_rsp(base + 2);
    chk("bad_starts", starts - s0, 32'd1);
    chk("bad_then_tag", last_tag, 8'h31);

    // Response backpressure.
    lat_fix = 3;
    rsp_ready = 1'b0;
    base = rsp_cnt;
    d0 = mk(8'h40, 32'h0102_0202, 32'h0001_0001);
    d1 = mk(8'h41, 32'h0102_0202, 32'h0001_0001);
    push(d0, 1'b0);
    push(d1, 1'b0);
    for (int n = 0; n < 50 && !rsp_valid; n++) tick();
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    s0 = starts;
    tick(10);
    chk("bp_nostart", starts - s0, 32'd0);
    chk("bp_held_valid", 32'(rsp_valid), 32'd1);
    chk("bp_held_tag", rsp_tag, 8'h40);
    chk("bp_held_res", rsp_result, d0.ip ^ K);
    rsp_ready = 1'b1;
    found = 1'b0;
    repeat (2) begin
      tick();
      if (unit_start) found = 1'b1;
    end
    chk("bp_restart", 32'(found), 32'd1);
    wait_rsp(base + 2);

    // Reset in the middle of a job with another one queued.
    lat_fix = 8;
    push(mk(8'h50, 32'h0101_0101, 32'h0001_0001), 1'b0);
    tick();
    push(mk(8'h51, 32'h0101_0101, 32'h0001_0001), 1'b0);
    chk("mid_count", 32'(queue_count), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_start", 32'(unit_start), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(queue_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_ip", unit_input_ptr, 32'd0);
    chk("mid_rst_pad", unit_padding, 32'd0);
    chk("mid_rst_tag", rsp_tag, 32'd0);
    chk("mid_rst_res", rsp_result, 32'd0);
    chk("mid_rst_sts", rsp_status, 32'd0);
    sb.delete();
    exp_starts = 0;
    rst = 1'b0;
    base = rsp_cnt;
    tick(12);
    chk("mid_no_rsp", rsp_cnt - base, 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);

`ifdef DWCONV_DISPATCH_TIMEOUT_EN
    // Unit never finishes: abort exactly TMO cycles into WAIT_DONE.
    hang = 1'b1;
    base = rsp_cnt;
    push(mk(8'h60, 32'h0101_0101, 32'h0001_0001), 1'b1);
    for (int n = 0; n < 20 && !unit_start; n++) tick();
    chk("to_start", 32'(unit_start), 32'd1);
    tick(TMO);
    chk("to_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_valid", 32'(rsp_valid), 32'd1);
    wait_rsp(base + 1);
    chk("to_sts", last_sts, 2'd1);
    chk("to_res", last_res, 32'd0);
    hang = 1'b0;
    // Done in the last counted cycle wins.
    lat_fix = TMO;
    push(mk(8'h61, 32'h0101_0101, 32'h0001_0001), 1'b0);
    wait_rsp(base + 2);
    chk("to_edge_sts", last_sts, 2'd0);
    // One cycle later is a timeout; the late done is ignored.
    lat_fix = TMO + 1;
    push(mk(8'h62, 32'h0101_0101, 32'h0001_0001), 1'b1);
    wait_rsp(base + 3);
    chk("to_late_sts", last_sts, 2'd1);
    tick(5);
`endif

    // Random traffic against the queue reference.
    lat_fix = 0;
    base = rsp_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] idm;
          logic [31:0] str;
          tick($urandom_range(0, 3));
          idm = $urandom;
          if ($urandom_range(0, 4) == 0) idm[7:0] = 8'd0;
          str[31:16] = ($urandom_range(0, 7) == 0) ? 16'd0
                     : 16'($urandom_range(1, 4));
          str[15:0]  = ($urandom_range(0, 7) == 0) ? 16'd0
                     : 16'($urandom_range(1, 4));
          push(mk(8'(8'h80 + i), idm, str), 1'b0);
        end
      end
      begin
        for (int n = 0; n < 20000 && rsp_cnt < base + 40; n++) begin
          tick();
          rsp_ready  = ($urandom_range(0, 2) != 0);
          unit_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready  = 1'b1;
        unit_ready = 1'b1;
      end
    join
    chk("rand_rsp", rsp_cnt - base, 32'd40);
    for (int n = 0; n < 100 && busy; n++) tick();
    chk("end_idle", 32'(busy), 32'd0);
    chk("end_starts", starts, exp_starts);
    chk("end_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
